// File: rtl/key_event_pkg.sv
// Shared constants for the keyboard event queue: entry layout and defaults.
package key_event_pkg;

  // Event entry layout: {repeat, make, code[8:0]}
  localparam int EV_W          = 11;
  localparam int EV_CODE_LSB   = 0;
  localparam int EV_CODE_W     = 9;
  localparam int EV_MAKE_BIT   = 9;
  localparam int EV_REPEAT_BIT = 10;

  // Number of distinct {extend, scan code} values tracked by the held vector
  localparam int NUM_KEYS = 512;

  // Default FIFO depth for the event queue
  localparam int KEY_DEPTH_DEFAULT = 8;

  // Assemble one queue entry from its fields
  function automatic logic [EV_W-1:0] pack_event(input logic rep,
                                                 input logic mk,
                                                 input logic [EV_CODE_W-1:0] code);
    return {rep, mk, code};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead synchronous FIFO. The head entry is presented
// combinationally from storage at the read pointer; full/empty come from
// the occupancy counter so pointers may simply wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active low
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,  // zero while empty
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             push_ok_o     // push accepted this cycle
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_c, empty_c, pop_ok_c, push_ok_c;

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CW'(DEPTH));
  // A pop when full frees the slot the simultaneous push will use
  assign pop_ok_c  = pop_i & ~empty_c;
  assign push_ok_c = push_i & (~full_c | pop_ok_c);

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = empty_c ? '0 : mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign empty_o     = empty_c;
  assign push_ok_o   = push_ok_c;

endmodule

// File: rtl/key_event_queue.sv
// Turns PS/2 decoder key_valid pulses into make/break/repeat events and
// queues them for the game logic. A held-key shadow vector identifies
// typematic repeats, which can optionally be discarded.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int DEPTH       = KEY_DEPTH_DEFAULT,
  parameter int DROP_REPEAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,           // asynchronous, active low
  input  logic                   key_valid,
  input  logic [8:0]             last_change,
  input  logic [511:0]           key_down,
  input  logic                   pop,
  input  logic                   clr_overflow,
  output logic                   ev_valid,
  output logic [8:0]             ev_code,
  output logic                   ev_make,
  output logic                   ev_repeat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  logic [NUM_KEYS-1:0] held_q, held_d;
  logic                overflow_q, overflow_d;
  logic                make_c, repeat_c, push_req_c, drop_c;
  logic                push_ok, fifo_empty;
  logic [EV_W-1:0]     head_data;

  // The decoder has already updated key_down for this event, so the bit
  // for the changed key tells make vs break. A make for a key we already
  // saw held is a typematic repeat.
  assign make_c     = key_down[last_change];
  assign repeat_c   = make_c & held_q[last_change];
  assign drop_c     = (DROP_REPEAT != 0) & repeat_c;
  assign push_req_c = key_valid & ~drop_c;

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req_c),
    .push_data_i (pack_event(repeat_c, make_c, last_change)),
    .pop_i       (pop),
    .head_data_o (head_data),
    .count_o     (count),
    .empty_o     (fifo_empty),
    .push_ok_o   (push_ok)
  );

  // Held-key shadow tracks every event, including dropped ones; overflow
  // sets on a rejected push and a same-cycle clear loses to the set
  always_comb begin
    held_d     = held_q;
    overflow_d = overflow_q;
    if (key_valid) held_d[last_change] = make_c;
    if (clr_overflow) overflow_d = 1'b0;
    if (push_req_c && !push_ok) overflow_d = 1'b1;
  end

  // Held vector and sticky overflow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  assign ev_valid  = ~fifo_empty;
  assign ev_code   = head_data[EV_CODE_LSB +: EV_CODE_W];
  assign ev_make   = head_data[EV_MAKE_BIT];
  assign ev_repeat = head_data[EV_REPEAT_BIT];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: two instances (repeat-dropping and
// repeat-keeping) share stimulus and are checked against a queue model.
module tb_key_event_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         pop;
  logic         clr_overflow;

  logic [1:0]    valid_w, make_w, rep_w, ovf_w;
  logic [8:0]    code_w  [2];
  logic [CW-1:0] count_w [2];

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 models DROP_REPEAT=1, index 1 DROP_REPEAT=0
  logic [10:0]  mq [2][$];
  logic [511:0] mh [2];
  bit           mo [2];
  logic [511:0] pressed;

  always #5 clk = ~clk;

  key_event_queue #(.DEPTH(DEPTH), .DROP_REPEAT(1)) dut_drop (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .pop(pop), .clr_overflow(clr_overflow),
    .ev_valid(valid_w[0]), .ev_code(code_w[0]), .ev_make(make_w[0]),
    .ev_repeat(rep_w[0]), .count(count_w[0]), .overflow(ovf_w[0])
  );

  key_event_queue #(.DEPTH(DEPTH), .DROP_REPEAT(0)) dut_keep (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .pop(pop), .clr_overflow(clr_overflow),
    .ev_valid(valid_w[1]), .ev_code(code_w[1]), .ev_make(make_w[1]),
    .ev_repeat(rep_w[1]), .count(count_w[1]), .overflow(ovf_w[1])
  );

  function automatic logic [8:0] exp_code(input int i);
    logic [10:0] e;
    if (mq[i].size() == 0) return 9'd0;
    e = mq[i][0];
    return e[8:0];
  endfunction

  function automatic logic exp_make(input int i);
    logic [10:0] e;
    if (mq[i].size() == 0) return 1'b0;
    e = mq[i][0];
    return e[9];
  endfunction

  function automatic logic exp_rep(input int i);
    logic [10:0] e;
    if (mq[i].size() == 0) return 1'b0;
    e = mq[i][0];
    return e[10];
  endfunction

  // One clock of stimulus; the model advances on the same edge
  task automatic drive(input bit kv, input logic [8:0] code, input bit mk,
                       input bit pp, input bit clr);
    if (kv) pressed[code] = mk;
    key_valid    = kv;
    last_change  = code;
    key_down     = pressed;
    pop          = pp;
    clr_overflow = clr;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit m, r, push, set;
      m = pressed[code];
      r = m && mh[i][code];
      if (kv) mh[i][code] = m;
      push = kv && !(r && (i == 0));
      if (pp && mq[i].size() > 0) void'(mq[i].pop_front());
      set = 1'b0;
      if (push) begin
        if (mq[i].size() < DEPTH) mq[i].push_back({r, m, code});
        else set = 1'b1;
      end
      if (clr) mo[i] = 1'b0;
      if (set) mo[i] = 1'b1;
    end
    #1;
    key_valid    = 1'b0;
    pop          = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH + 2; n++) begin
      if (mq[0].size() == 0 && mq[1].size() == 0) break;
      drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; key_valid = 1'b0; last_change = '0; key_down = '0;
    pop = 1'b0; clr_overflow = 1'b0; pressed = '0;
    for (int i = 0; i < 2; i++) begin mq[i].delete(); mh[i] = '0; mo[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (valid_w[i] !== 1'b0) begin errors++; $display("FAIL reset_valid inst%0d got %b want 0", i, valid_w[i]); end
      checks++; if (code_w[i] !== 9'd0) begin errors++; $display("FAIL reset_code inst%0d got %h want 000", i, code_w[i]); end
      checks++; if (make_w[i] !== 1'b0 || rep_w[i] !== 1'b0) begin errors++; $display("FAIL reset_flags inst%0d got make %b rep %b want 0 0", i, make_w[i], rep_w[i]); end
      checks++; if (count_w[i] !== '0) begin errors++; $display("FAIL reset_count inst%0d got %0d want 0", i, count_w[i]); end
      checks++; if (ovf_w[i] !== 1'b0) begin errors++; $display("FAIL reset_ovf inst%0d got %b want 0", i, ovf_w[i]); end
    end
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_press_release();
    drive(1'b1, 9'h01C, 1'b1, 1'b0, 1'b0);
    $display("press 01C");
    for (int i = 0; i < 2; i++) begin
      checks++; if (valid_w[i] !== 1'b1 || code_w[i] !== 9'h01C) begin errors++; $display("FAIL press_head inst%0d got valid %b code %h want 1 01c", i, valid_w[i], code_w[i]); end
      checks++; if (make_w[i] !== 1'b1 || rep_w[i] !== 1'b0) begin errors++; $display("FAIL press_flags inst%0d got make %b rep %b want 1 0", i, make_w[i], rep_w[i]); end
      checks++; if (count_w[i] !== CW'(1)) begin errors++; $display("FAIL press_count inst%0d got %0d want 1", i, count_w[i]); end
    end
    drive(1'b1, 9'h01C, 1'b0, 1'b0, 1'b0);
    $display("release 01C");
    drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    $display("pop");
    for (int i = 0; i < 2; i++) begin
      checks++; if (code_w[i] !== 9'h01C || make_w[i] !== 1'b0) begin errors++; $display("FAIL break_head inst%0d got code %h make %b want 01c 0", i, code_w[i], make_w[i]); end
      checks++; if (count_w[i] !== CW'(1)) begin errors++; $display("FAIL break_count inst%0d got %0d want 1", i, count_w[i]); end
    end
    drain();
  endtask

  task automatic test_repeat();
    logic [2:0] want_rep;
    want_rep = 3'b110;  // bit k = repeat flag of k-th entry
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 9'h11D, 1'b1, 1'b0, 1'b0);
      $display("make 11D #%0d", k);
    end
    checks++; if (count_w[0] !== CW'(1)) begin errors++; $display("FAIL repeat_drop_count got %0d want 1", count_w[0]); end
    checks++; if (count_w[1] !== CW'(3)) begin errors++; $display("FAIL repeat_keep_count got %0d want 3", count_w[1]); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (code_w[1] !== 9'h11D || rep_w[1] !== want_rep[k] || make_w[1] !== 1'b1) begin
        errors++; $display("FAIL repeat_keep_entry%0d got code %h rep %b make %b want 11d %b 1", k, code_w[1], rep_w[1], make_w[1], want_rep[k]);
      end
      drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
      $display("pop repeat entry %0d", k);
    end
    drive(1'b1, 9'h11D, 1'b0, 1'b0, 1'b0);
    checks++; if (count_w[0] !== CW'(1) || make_w[0] !== 1'b0) begin errors++; $display("FAIL repeat_break got count %0d make %b want 1 0", count_w[0], make_w[0]); end
    drain();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 9'(9'h040 + k), 1'b1, 1'b0, 1'b0);
      $display("make %h", 9'(9'h040 + k));
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_w[i] !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count inst%0d got %0d want %0d", i, count_w[i], DEPTH); end
      checks++; if (ovf_w[i] !== 1'b1) begin errors++; $display("FAIL ovf_flag inst%0d got %b want 1", i, ovf_w[i]); end
      checks++; if (code_w[i] !== 9'h040) begin errors++; $display("FAIL ovf_head inst%0d got %h want 040", i, code_w[i]); end
    end
    // Set and clear in the same cycle: set must win
    drive(1'b1, 9'h049, 1'b1, 1'b0, 1'b1);
    $display("make 049 with clr on full");
    for (int i = 0; i < 2; i++) begin
      checks++; if (ovf_w[i] !== 1'b1) begin errors++; $display("FAIL ovf_setwins inst%0d got %b want 1", i, ovf_w[i]); end
    end
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    $display("clr_overflow");
    for (int i = 0; i < 2; i++) begin
      checks++; if (ovf_w[i] !== 1'b0) begin errors++; $display("FAIL ovf_clear inst%0d got %b want 0", i, ovf_w[i]); end
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b1, 9'h04A, 1'b1, 1'b1, 1'b0);
    $display("make 04A with pop on full");
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_w[i] !== CW'(DEPTH) || ovf_w[i] !== 1'b0) begin errors++; $display("FAIL fullpp inst%0d got count %0d ovf %b want %0d 0", i, count_w[i], ovf_w[i], DEPTH); end
      checks++; if (code_w[i] !== 9'h041) begin errors++; $display("FAIL fullpp_head inst%0d got %h want 041", i, code_w[i]); end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) begin
        checks++; if (code_w[0] !== 9'h04A) begin errors++; $display("FAIL fullpp_tail got %h want 04a", code_w[0]); end
      end else begin
        checks++; if (code_w[1] !== exp_code(1)) begin errors++; $display("FAIL fullpp_order%0d got %h want %h", k, code_w[1], exp_code(1)); end
      end
      drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
      $display("pop %0d", k);
    end
    checks++; if (count_w[0] !== '0 || valid_w[0] !== 1'b0) begin errors++; $display("FAIL fullpp_empty got count %0d valid %b want 0 0", count_w[0], valid_w[0]); end
  endtask

  task automatic test_empty_pop();
    drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    $display("pop on empty");
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_w[i] !== '0 || valid_w[i] !== 1'b0) begin errors++; $display("FAIL emptypop inst%0d got count %0d valid %b want 0 0", i, count_w[i], valid_w[i]); end
    end
    drive(1'b1, 9'h055, 1'b1, 1'b1, 1'b0);
    $display("make 055 with pop on empty");
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_w[i] !== CW'(1) || code_w[i] !== 9'h055) begin errors++; $display("FAIL emptypp inst%0d got count %0d code %h want 1 055", i, count_w[i], code_w[i]); end
    end
    drain();
  endtask

  task automatic test_random();
    logic [8:0] codes [6];
    logic [8:0] c;
    bit kv, mk, pp, clr;
    codes[0] = 9'h01C; codes[1] = 9'h11D; codes[2] = 9'h023;
    codes[3] = 9'h1F4; codes[4] = 9'h000; codes[5] = 9'h1FF;
    for (int cyc = 0; cyc < 300; cyc++) begin
      kv  = ($urandom_range(0, 2) == 0);
      c   = codes[$urandom_range(0, 5)];
      mk  = ($urandom_range(0, 2) != 0);
      pp  = (cyc < 150) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      clr = ($urandom_range(0, 15) == 0);
      drive(kv, c, mk, pp, clr);
      $display("rand cyc %0d kv %b code %h make %b pop %b clr %b count %0d/%0d", cyc, kv, c, mk, pp, clr, count_w[0], count_w[1]);
      for (int i = 0; i < 2; i++) begin
        checks++; if (count_w[i] !== CW'(mq[i].size())) begin errors++; $display("FAIL rand_count inst%0d cyc %0d got %0d want %0d", i, cyc, count_w[i], mq[i].size()); end
        checks++; if (valid_w[i] !== (mq[i].size() > 0)) begin errors++; $display("FAIL rand_valid inst%0d cyc %0d got %b", i, cyc, valid_w[i]); end
        checks++; if ({rep_w[i], make_w[i], code_w[i]} !== {exp_rep(i), exp_make(i), exp_code(i)}) begin
          errors++; $display("FAIL rand_head inst%0d cyc %0d got %b %b %h want %b %b %h", i, cyc, rep_w[i], make_w[i], code_w[i], exp_rep(i), exp_make(i), exp_code(i));
        end
        checks++; if (ovf_w[i] !== mo[i]) begin errors++; $display("FAIL rand_ovf inst%0d cyc %0d got %b want %b", i, cyc, ovf_w[i], mo[i]); end
      end
    end
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 9'(9'h030 + k), 1'b1, 1'b0, 1'b0);
      $display("make %h", 9'(9'h030 + k));
    end
    checks++; if (count_w[0] !== CW'(5)) begin errors++; $display("FAIL rstmid_pre got %0d want 5", count_w[0]); end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin mq[i].delete(); mh[i] = '0; mo[i] = 1'b0; end
    $display("async reset asserted");
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_w[i] !== '0 || valid_w[i] !== 1'b0) begin errors++; $display("FAIL rstmid inst%0d got count %0d valid %b want 0 0", i, count_w[i], valid_w[i]); end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 9'h030, 1'b1, 1'b0, 1'b0);
    $display("make 030 after reset");
    for (int i = 0; i < 2; i++) begin
      checks++; if (valid_w[i] !== 1'b1 || rep_w[i] !== 1'b0 || code_w[i] !== 9'h030) begin errors++; $display("FAIL rstmid_held inst%0d got valid %b rep %b code %h want 1 0 030", i, valid_w[i], rep_w[i], code_w[i]); end
    end
    drive(1'b1, 9'h030, 1'b1, 1'b0, 1'b0);
    $display("repeat make 030");
    checks++; if (count_w[0] !== CW'(1) || count_w[1] !== CW'(2)) begin errors++; $display("FAIL rstmid_repeat got %0d/%0d want 1/2", count_w[0], count_w[1]); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_repeat();
    test_overflow();
    test_full_push_pop();
    test_empty_pop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
